// File: rtl/cpu_pkg.sv
// Shared constants, forward-select encoding and NOP control values for the EX pipeline.
// Forwarding is compiled in only when ID_EX_FWD_EN is defined.
package cpu_pkg;

    localparam int unsigned ALUCTL_W = 5;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Control bundle carried from ID into EX.
    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_read;
        logic                alu_src;
        logic                sign;
        logic [ALUCTL_W-1:0] alu_ctl;
        logic [OPCODE_W-1:0] opcode;
    } ex_ctrl_t;

    localparam ex_ctrl_t NOP_CTRL = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        alu_src:   1'b0,
        sign:      1'b0,
        alu_ctl:   ALUCTL_W'(0),
        opcode:    OPCODE_W'(0)
    };

endpackage

// File: rtl/forward_mux.sv
// Per-operand forward select (EX/MEM over MEM/WB over stored data; r0 never forwarded).
// With ID_EX_FWD_EN undefined the stored register data always passes through.
module forward_mux
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_addr_i,
    input  logic [DATA_W-1:0]     reg_data_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0]     exmem_value_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0]     memwb_value_i,
    output logic [DATA_W-1:0]     fwd_data_o
);

    fwd_sel_e sel;

`ifdef ID_EX_FWD_EN
    always_comb begin
        sel = FWD_REG;
        if (exmem_reg_write_i && (exmem_rd_i != REG_ADDR_W'(REG_ZERO)) && (exmem_rd_i == src_addr_i)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_rd_i != REG_ADDR_W'(REG_ZERO)) && (memwb_rd_i == src_addr_i)) begin
            sel = FWD_MEMWB;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{src_addr_i, exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i};
    assign sel        = FWD_REG;
`endif

    always_comb begin
        case (sel)
            FWD_EXMEM: fwd_data_o = exmem_value_i;
            FWD_MEMWB: fwd_data_o = memwb_value_i;
            default:   fwd_data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use interlock feeding the ALU.
// Define ID_EX_FWD_EN to enable forwarding; otherwise RAW hazards stall until the producer retires.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_alu_src,
    input  logic                  id_uses_rt,
    input  logic [ALUCTL_W-1:0]   id_ALUctl,
    input  logic                  id_sign,
    input  logic [OPCODE_W-1:0]   id_OpCode,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_value,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_value,
    input  logic                  flush,
    input  logic                  ex_stall,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [DATA_W-1:0]     in1,
    output logic [DATA_W-1:0]     in2,
    output logic [ALUCTL_W-1:0]   ALUctl,
    output logic                  sign,
    output logic [OPCODE_W-1:0]   OpCode,
    output logic [DATA_W-1:0]     ex_store_data
);

    ex_ctrl_t              ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
    logic [DATA_W-1:0]     rs_data_q, rs_data_d;
    logic [DATA_W-1:0]     rt_data_q, rt_data_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [DATA_W-1:0]     fwd_rs, fwd_rt;
    logic                  load_use, raw_hazard, hazard;

    // True when a writing, nonzero destination is read by the instruction in ID.
    function automatic logic src_hit(input logic                  wr,
                                     input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt,
                                     input logic                  uses_rt);
        return wr && (dst != REG_ADDR_W'(REG_ZERO)) && ((rs == dst) || (uses_rt && (rt == dst)));
    endfunction

    forward_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .src_addr_i        (rs_addr_q),
        .reg_data_i        (rs_data_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_value_i     (exmem_value),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_value_i     (memwb_value),
        .fwd_data_o        (fwd_rs)
    );

    forward_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .src_addr_i        (rt_addr_q),
        .reg_data_i        (rt_data_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_value_i     (exmem_value),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_value_i     (memwb_value),
        .fwd_data_o        (fwd_rt)
    );

    // Hazard detection; without forwarding every in-flight producer blocks its readers.
    always_comb begin
        load_use = id_valid &&
                   src_hit(ctrl_q.valid && ctrl_q.mem_read, rd_q, id_rs_addr, id_rt_addr, id_uses_rt);
`ifdef ID_EX_FWD_EN
        raw_hazard = 1'b0;
`else
        raw_hazard = id_valid &&
                     (src_hit(ctrl_q.reg_write, rd_q,     id_rs_addr, id_rt_addr, id_uses_rt) ||
                      src_hit(exmem_reg_write,  exmem_rd, id_rs_addr, id_rt_addr, id_uses_rt) ||
                      src_hit(memwb_reg_write,  memwb_rd, id_rs_addr, id_rt_addr, id_uses_rt));
`endif
        hazard   = load_use || raw_hazard;
        stall_id = reset && ((hazard && !flush) || ex_stall);
    end

    // Next-state: flush > hold (with operand refresh) > bubble > capture.
    always_comb begin
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (flush) begin
            ctrl_d.valid     = 1'b0;
            ctrl_d.reg_write = 1'b0;
            ctrl_d.mem_read  = 1'b0;
        end else if (ex_stall) begin
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end else if (hazard) begin
            ctrl_d    = NOP_CTRL;
            rd_d      = '0;
            rs_addr_d = '0;
            rt_addr_d = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
        end else begin
            ctrl_d = '{valid:     id_valid,
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read,
                       alu_src:   id_alu_src,
                       sign:      id_sign,
                       alu_ctl:   id_ALUctl,
                       opcode:    id_OpCode};
            rd_d      = id_rd_addr;
            rs_addr_d = id_rs_addr;
            rt_addr_d = id_rt_addr;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= NOP_CTRL;
            rd_q      <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ALUctl        = ctrl_q.alu_ctl;
    assign sign          = ctrl_q.sign;
    assign OpCode        = ctrl_q.opcode;
    assign in1           = fwd_rs;
    assign in2           = ctrl_q.alu_src ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule
